uart_tx_buf: RTL and testbench
==============================

# uart_tx_buf

Memory-mapped transmit FIFO placed upstream of the `uart` peripheral. Software pushes bytes into the FIFO over the peripheral bus without polling. A drain state machine then acts as a bus master on the `uart` register port: it polls the UART status register and writes each byte to the UART TXDATA register once the transmitter is idle. Reads of the UART RX registers are not routed through this block.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes; legal range 1..7.
- `UART_BASE_STATUS`, default 8'h04: UART status register offset.
- `UART_BASE_TXDATA`, default 8'h0C: UART TXDATA register offset.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `we_i`, in, 1: slave write strobe.
- `addr_i`, in, 32: slave address; only [7:0] is decoded.
- `data_i`, in, 32: slave write data.
- `data_o`, out, 32: slave read data; combinational on `addr_i`.
- `uart_we_o`, out, 1: master write strobe to `uart`.
- `uart_addr_o`, out, 32: master address to `uart`.
- `uart_data_o`, out, 32: master write data to `uart`.
- `uart_data_i`, in, 32: `uart` combinational read data.
- `irq_o`, out, 1: low-water interrupt. Present only with `UART_TX_BUF_IRQ_EN`.

## Operation
Slave registers, decoded on `addr_i[7:0]`:
- **0x00 CTRL (rw)**
  - bit0 `drain_en`.
  - bit1 `flush`: write-only, self-clearing, reads 0. Writing 1 empties the FIFO.
- **0x04 STATUS (ro except bit3)**
  - bit0 `full`, bit1 `empty`, bit2 `busy` (FSM not in IDLE).
  - bit3 `ovf`: sticky; cleared by writing 1 to bit3.
  - [15:8] `count`.
- **0x08 TXDATA (wo)**
  - Pushes `data_i[7:0]`.
  - If `full`, the push is dropped and `ovf` is set.
  - Full is evaluated on the pre-edge count, so a push is rejected even when a pop happens in the same cycle.
- **0x0C THRESH (rw)**: [7:0] low-water level. Exists only with the macro; otherwise reads 0 and writes are ignored.
- Any other address reads 0 and ignores writes.

FIFO:
- Circular buffer with read and write pointers of DEPTH_LOG2 bits; both wrap modulo depth.
- `count` is DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.
- A simultaneous push and pop leaves `count` unchanged.

Drain FSM, states IDLE, POLL, WRITE, CONFIRM:
- **IDLE**: go to POLL when `drain_en` and not `empty`.
- **POLL**: drive `uart_addr_o`=UART_BASE_STATUS, `uart_we_o`=0.
  - If `uart_data_i[0]`=0, go to WRITE; otherwise stay in POLL.
  - If `drain_en` drops, return to IDLE.
- **WRITE**: drive `uart_we_o`=1, `uart_addr_o`=UART_BASE_TXDATA, `uart_data_o`={24'h0, head byte}. Go to CONFIRM unconditionally.
- **CONFIRM**: drive `uart_addr_o`=UART_BASE_STATUS, `uart_we_o`=0.
  - If `uart_data_i[0]`=1, the UART accepted the byte: pop the FIFO and go to IDLE.
  - Otherwise (UART TX disabled, write ignored), do not pop and go to POLL to retry.
- A flush takes effect in any state: pointers and count go to 0, the FSM goes to IDLE, and a pop in the same cycle is suppressed.
- Outside the states listed above, `uart_we_o`=0, `uart_addr_o`=UART_BASE_STATUS, and `uart_data_o` holds its previous value.

## Timing
- Reset values:
  - `uart_we_o`=0, `uart_addr_o`=0x04, `uart_data_o`=0, `irq_o`=0.
  - FIFO empty, CTRL=0, `ovf`=0, THRESH=0.
  - `data_o`=0 while `rst_n`=0.
- A reset asserted mid-transfer abandons the transfer; the FIFO contents are discarded.
- Register writes take effect at the clock edge. STATUS reflects a push one cycle later.
- Minimum handoff latency: push at edge N, IDLE→POLL at N+1, WRITE at N+2, CONFIRM at N+3, pop at N+4. The UART receives `we` during the cycle after N+2.
- `uart_we_o` is asserted for exactly one cycle per attempt, and never in consecutive cycles.
- Sustained rate is bounded by the UART frame time; the FSM adds at most 4 cycles of overhead per byte.

## Configuration
- `UART_TX_BUF_IRQ_EN`
  - **Defined**: THRESH register and `irq_o` exist. `irq_o` is registered, equal to (`count` ≤ THRESH) && `drain_en`, and updates one cycle after the count changes.
  - **Undefined**: no `irq_o` port, no THRESH storage, 0x0C reads 0.

## Test plan
- **Basic drain:** UART model with baud 4 and TX enabled; CTRL=1; push 0x55 → exactly one `uart_we_o` pulse with addr 0x0C, data 0x55; STATUS returns to 0x0002 (empty) after the pop.
- **Fill and overflow:** with DEPTH_LOG2=4 and drain off, push 17 bytes → STATUS bit0=1, count=16, bit3 (`ovf`)=1. Write 0x08 to STATUS → `ovf`=0. Enable drain → 16 bytes arrive in push order; the 17th is never seen.
- **Wrap-around:** push 10, drain 10, push 10 → all 20 bytes are delivered in order, with the pointers crossing index 15→0.
- **TX disabled retry:** UART ctrl=0, drain on, push 0xA5 → FSM cycles POLL/WRITE/CONFIRM and count stays 1. Set UART ctrl=1 → 0xA5 is delivered once and count becomes 0.
- **Flush during CONFIRM:** write CTRL=0x3 while in CONFIRM with `uart_data_i[0]`=1 → count=0, FSM in IDLE, no further `uart_we_o`.
- **IRQ (macro defined):** THRESH=2, drain on, 5 bytes queued → `irq_o` rises the cycle after count drops to 2 and stays high while count is 0..2.

Source files
------------

// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//
// Memory-mapped transmit FIFO that sits in front of the `uart` peripheral.
// Software pushes bytes over the slave port without polling. A small drain
// state machine then masters the UART register port: it polls the UART
// status register and writes one byte at a time to TXDATA when the
// transmitter is idle. It pops the FIFO only once the UART reports that it
// took the byte.
//
// Slave register map (addr_i[7:0]):
//   0x00 CTRL   : bit0 drain_en (rw), bit1 flush (wo, self-clearing)
//   0x04 STATUS : bit0 full, bit1 empty, bit2 busy, bit3 ovf (write 1 clears),
//                 [15:8] count
//   0x08 TXDATA : write pushes data_i[7:0]; dropped and ovf set when full
//   0x0C THRESH : low-water level, only with UART_TX_BUF_IRQ_EN
//
// Optional feature macro: UART_TX_BUF_IRQ_EN
//   Defined   -> THRESH register and registered irq_o output exist.
//   Undefined -> no irq_o port, and 0x0C reads as zero.
//
// Reset is synchronous and active-low (rst_n).
// -----------------------------------------------------------------------------
module uart_tx_buf #(
    parameter int         DEPTH_LOG2       = 4,
    parameter logic [7:0] UART_BASE_STATUS = 8'h04,
    parameter logic [7:0] UART_BASE_TXDATA = 8'h0C
) (
    input  logic        clk,
    input  logic        rst_n,
    // slave port
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    // master port towards the uart
    output logic        uart_we_o,
    output logic [31:0] uart_addr_o,
    output logic [31:0] uart_data_o,
    input  logic [31:0] uart_data_i
`ifdef UART_TX_BUF_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    // -------------------------------------------------------------------------
    // Local constants and types
    // -------------------------------------------------------------------------
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_TXDATA = 8'h08;
`ifdef UART_TX_BUF_IRQ_EN
    localparam logic [7:0] ADDR_THRESH = 8'h0C;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_POLL    = 2'd1,
        S_WRITE   = 2'd2,
        S_CONFIRM = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_drain_en;
    logic                  r_ovf;
    logic [7:0]            r_data_hold;
    state_t                r_state;
    state_t                w_state_next;

`ifdef UART_TX_BUF_IRQ_EN
    logic [7:0]            r_thresh;
    logic                  r_irq;
`endif

    logic [7:0]  w_addr;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_wr_txdata;
    logic        w_flush;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_head;
    logic [31:0] w_rdata;
    logic        w_unused;

    // -------------------------------------------------------------------------
    // Slave address decode and FIFO flags
    // -------------------------------------------------------------------------
    assign w_addr      = addr_i[7:0];
    assign w_wr_ctrl   = we_i && (w_addr == ADDR_CTRL);
    assign w_wr_status = we_i && (w_addr == ADDR_STATUS);
    assign w_wr_txdata = we_i && (w_addr == ADDR_TXDATA);
    assign w_flush     = w_wr_ctrl && data_i[1];

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_busy  = (r_state != S_IDLE);
    assign w_head  = r_mem[r_rd_ptr];

    // Full is judged on the pre-edge count, so a push into a full FIFO is
    // rejected even if the drain pops in the same cycle.
    assign w_push = w_wr_txdata && !w_full;

    // The UART showing busy in CONFIRM means it took the byte. A flush in the
    // same cycle wins and suppresses the pop.
    assign w_pop = (r_state == S_CONFIRM) && uart_data_i[0] && !w_empty && !w_flush;

    // Upper address/data bits and the rest of the UART status word carry no
    // meaning for this block.
    assign w_unused = ^{addr_i[31:8], data_i[31:8], uart_data_i[31:1]};

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // Write the pushed byte into the slot at the write pointer.
    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so clearing the RAM would only cost logic.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i[7:0];
        end
    end

    // Advance the pointers and track the occupancy; reset and flush empty the FIFO.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, whatever the order of the always blocks.
    always_ff @(posedge clk) begin
        if (!rst_n || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control and status registers
    // -------------------------------------------------------------------------
    // CTRL.drain_en follows software writes. The flush bit is not stored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drain_en <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_drain_en <= data_i[0];
        end
    end

    // Sticky overflow flag: set by a dropped push, cleared by writing 1 to STATUS bit3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_wr_txdata && w_full) begin
            r_ovf <= 1'b1;
        end else if (w_wr_status && data_i[3]) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef UART_TX_BUF_IRQ_EN
    // Low-water threshold register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_thresh <= 8'h00;
        end else if (we_i && (w_addr == ADDR_THRESH)) begin
            r_thresh <= data_i[7:0];
        end
    end

    // Registered low-water interrupt; it follows the count one cycle late.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (8'(r_count) <= r_thresh) && r_drain_en;
        end
    end

    assign irq_o = r_irq;
`endif

    // Combinational slave read mux; reads are forced to zero while in reset.
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rdata = 32'h0;
        if (rst_n) begin
            case (w_addr)
                ADDR_CTRL:   w_rdata = {31'h0, r_drain_en};
                ADDR_STATUS: w_rdata = {16'h0, 8'(r_count), 4'h0,
                                        r_ovf, w_busy, w_empty, w_full};
`ifdef UART_TX_BUF_IRQ_EN
                ADDR_THRESH: w_rdata = {24'h0, r_thresh};
`endif
                default:     w_rdata = 32'h0;
            endcase
        end
    end

    assign data_o = w_rdata;

    // -------------------------------------------------------------------------
    // Drain state machine
    // -------------------------------------------------------------------------
    // State register; a flush returns to IDLE from any state.
    always_ff @(posedge clk) begin
        if (!rst_n || w_flush) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state. uart_data_i[0] is the UART transmitter busy flag.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_drain_en && !w_empty) begin
                    w_state_next = S_POLL;
                end
            end
            S_POLL: begin
                if (!r_drain_en) begin
                    w_state_next = S_IDLE;
                end else if (!uart_data_i[0]) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = S_CONFIRM;
            end
            S_CONFIRM: begin
                // Busy means the byte was taken. Idle means TX is disabled
                // and the write was ignored, so the write is tried again.
                if (uart_data_i[0]) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_POLL;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Master port outputs, decoded from the current state only.
    always_comb begin
        uart_we_o   = 1'b0;
        uart_addr_o = {24'h0, UART_BASE_STATUS};
        uart_data_o = {24'h0, r_data_hold};
        case (r_state)
            S_POLL, S_CONFIRM: begin
                uart_addr_o = {24'h0, UART_BASE_STATUS};
            end
            S_WRITE: begin
                uart_we_o   = 1'b1;
                uart_addr_o = {24'h0, UART_BASE_TXDATA};
                uart_data_o = {24'h0, w_head};
            end
            default: begin
                uart_we_o = 1'b0;
            end
        endcase
    end

    // Keep the last byte offered to the UART so uart_data_o stays stable
    // outside WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_hold <= 8'h00;
        end else if (r_state == S_WRITE) begin
            r_data_hold <= w_head;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buf
//
// Directed bench for uart_tx_buf with a behavioural UART model. Stimulus
// pushes the expected UART bytes into a scoreboard queue. A separate monitor
// compares every write the DUT issues to the UART against the head of that
// queue, and it pops the queue only when the UART model accepts the write.
// -----------------------------------------------------------------------------
module tb_uart_tx_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic        uart_we_o;
    logic [31:0] uart_addr_o;
    logic [31:0] uart_data_o;
    logic [31:0] uart_data_i;
`ifdef UART_TX_BUF_IRQ_EN
    logic        irq_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    bit         tx_en = 1'b1;
    int         busy_cnt;
    int         n_uart_writes = 0;
    int         n_accepted    = 0;
    bit         prev_we = 1'b0;

    uart_tx_buf #(
        .DEPTH_LOG2       (4),
        .UART_BASE_STATUS (8'h04),
        .UART_BASE_TXDATA (8'h0C)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .uart_we_o   (uart_we_o),
        .uart_addr_o (uart_addr_o),
        .uart_data_o (uart_data_o),
        .uart_data_i (uart_data_i)
`ifdef UART_TX_BUF_IRQ_EN
        ,
        .irq_o       (irq_o)
`endif
    );

    always #5 clk = ~clk;

    // UART model: a write to TXDATA while TX is enabled and idle starts a
    // 40-cycle frame (baud divisor 4, 10 bits). Status bit0 is tx busy.
    always @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt <= 0;
        end else if (uart_we_o && uart_addr_o[7:0] == 8'h0C && tx_en && busy_cnt == 0) begin
            busy_cnt <= 40;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign uart_data_i = (uart_addr_o[7:0] == 8'h04) ? {31'h0, busy_cnt != 0} : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: every UART write is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && uart_we_o) begin
                n_uart_writes++;
                check("uart_we_not_back_to_back", {31'h0, prev_we}, 32'h0);
                check("uart_write_addr", uart_addr_o, 32'h0000_000C);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_uart_write: got data 0x%08h, expected no write", uart_data_o);
                end else begin
                    check("uart_write_data", uart_data_o, {24'h0, exp_q[0]});
                    if (tx_en && busy_cnt == 0) begin
                        void'(exp_q.pop_front());
                        n_accepted++;
                    end
                end
            end
            prev_we = rst_n && uart_we_o;
        end
    end

    // Time limit on the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we_i   = 1'b1;
        addr_i = a;
        data_i = d;
        @(negedge clk);
        we_i   = 1'b0;
        addr_i = 32'h04;
        data_i = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_i = a;
        #1;
        d = data_o;
    endtask

    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        if (accept) exp_q.push_back(b);
        bus_write(32'h08, {24'h0, b});
    endtask

    // Waits until the FIFO is empty and the FSM has returned to IDLE.
    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            addr_i = 32'h04;
            #1;
            if (data_o[2:1] == 2'b01) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail(name);
    endtask

    // Changes the UART TX enable only while no UART write is in flight.
    task automatic set_tx_en(input bit v);
        @(negedge clk);
        while (uart_we_o) @(negedge clk);
        #2;
        tx_en = v;
    endtask

    initial begin
        int base;
        bit found;

        // ---------------- reset ----------------
        rst_n  = 1'b0;
        addr_i = 32'h04;
        repeat (3) @(negedge clk);
        #1;
        check("data_o_in_reset", data_o, 32'h0);
        check("reset_uart_we", {31'h0, uart_we_o}, 32'h0);
        check("reset_uart_addr", uart_addr_o, 32'h0000_0004);
        check("reset_uart_data", uart_data_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check_reg("reset_status", 32'h04, 32'h0000_0002);
        check_reg("reset_ctrl", 32'h00, 32'h0);
        check_reg("reset_reg_0c", 32'h0C, 32'h0);
        check_reg("unmapped_reads_zero", 32'h10, 32'h0);

        // ---------------- basic drain + handoff latency ----------------
        bus_write(32'h00, 32'h1);
        check_reg("ctrl_drain_en", 32'h00, 32'h1);
        push(8'h55, 1'b1);
        // push edge N has passed; IDLE here, POLL next, WRITE after that
        check("lat_idle_no_we", {31'h0, uart_we_o}, 32'h0);
        @(negedge clk);
        check("lat_poll_no_we", {31'h0, uart_we_o}, 32'h0);
        @(negedge clk);
        check("lat_write_we", {31'h0, uart_we_o}, 32'h1);
        wait_idle("basic_drain_wait", 200);
        check("uart_data_hold", uart_data_o, 32'h0000_0055);
        check_reg("basic_status_empty", 32'h04, 32'h0000_0002);
        check("basic_one_write", n_uart_writes, 1);
        check("basic_accepted", n_accepted, 1);

        // ---------------- fill and overflow ----------------
        bus_write(32'h00, 32'h0);
        for (int i = 0; i < 17; i++) begin
            push(8'h30 + 8'(i), i < 16);
        end
        check_reg("full_status", 32'h04, 32'h0000_1009);
        bus_write(32'h04, 32'h08);
        check_reg("ovf_cleared", 32'h04, 32'h0000_1001);
        bus_write(32'h00, 32'h1);
        wait_idle("fill_drain_wait", 2500);
        check("fill_scoreboard_empty", exp_q.size(), 0);
        check("fill_accepted", n_accepted, 17);

        // ---------------- wrap-around ----------------
        bus_write(32'h00, 32'h0);
        for (int i = 0; i < 10; i++) push(8'h80 + 8'(i), 1'b1);
        bus_write(32'h00, 32'h1);
        wait_idle("wrap_drain1_wait", 1500);
        bus_write(32'h00, 32'h0);
        for (int i = 0; i < 10; i++) push(8'h90 + 8'(i), 1'b1);
        bus_write(32'h00, 32'h1);
        wait_idle("wrap_drain2_wait", 1500);
        check("wrap_scoreboard_empty", exp_q.size(), 0);
        check("wrap_accepted", n_accepted, 37);

        // ---------------- TX disabled retry ----------------
        set_tx_en(1'b0);
        base = n_uart_writes;
        push(8'hA5, 1'b1);
        repeat (80) @(negedge clk);
        check_reg("retry_status", 32'h04, 32'h0000_0104);
        check("retry_multiple_attempts", {31'h0, (n_uart_writes - base) >= 2}, 32'h1);
        check("retry_not_accepted", n_accepted, 37);
        set_tx_en(1'b1);
        wait_idle("retry_drain_wait", 300);
        check("retry_accepted_once", n_accepted, 38);
        check_reg("retry_status_empty", 32'h04, 32'h0000_0002);

        // ---------------- flush during CONFIRM ----------------
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_we_o) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail("flush_wait_write");
        // next low phase is CONFIRM; issue the flush there
        @(negedge clk);
        check("confirm_sees_busy", {31'h0, uart_data_i[0]}, 32'h1);
        we_i   = 1'b1;
        addr_i = 32'h00;
        data_i = 32'h3;
        @(negedge clk);
        we_i   = 1'b0;
        addr_i = 32'h04;
        data_i = 32'h0;
        exp_q.delete();
        base = n_uart_writes;
        check_reg("flush_status", 32'h04, 32'h0000_0002);
        check_reg("flush_bit_reads_zero", 32'h00, 32'h1);
        repeat (100) @(negedge clk);
        check("flush_no_more_writes", n_uart_writes, base);
        check("flush_accepted", n_accepted, 39);

`ifdef UART_TX_BUF_IRQ_EN
        // ---------------- low-water interrupt ----------------
        begin
            bit          started = 1'b0;
            bit          prev_exp = 1'b0;
            logic [31:0] d;
            bus_write(32'h00, 32'h0);
            bus_write(32'h0C, 32'h2);
            check_reg("thresh_readback", 32'h0C, 32'h2);
            check("irq_low_drain_off", {31'h0, irq_o}, 32'h0);
            for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b1);
            bus_write(32'h00, 32'h1);
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                addr_i = 32'h04;
                #1;
                d = data_o;
                if (started) check("irq_tracks_count", {31'h0, irq_o}, {31'h0, prev_exp});
                prev_exp = (d[15:8] <= 8'd2);
                started  = 1'b1;
                if (d[2:1] == 2'b01) break;
            end
            @(negedge clk);
            check("irq_high_when_empty", {31'h0, irq_o}, 32'h1);
            check("irq_scoreboard_empty", exp_q.size(), 0);
        end
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
